// File: rtl/pb_operand_sequencer.sv
// Pushbutton load sequencer: synchronizes and debounces a raw button, then turns each
// accepted press into one single-cycle load strobe in the order A, B, OP, then SHOW.
module pb_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       clr,
    output logic       load_a,
    output logic       load_b,
    output logic       load_op,
    output logic [1:0] stage,
    output logic       result_valid
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_A    = 2'd0,
        ST_B    = 2'd1,
        ST_OP   = 2'd2,
        ST_SHOW = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic                   btn_db_q, btn_db_d;
    logic                   btn_db_prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press;
    state_t                 state_q, state_d;
    logic                   load_a_q, load_a_d;
    logic                   load_b_q, load_b_d;
    logic                   load_op_q, load_op_d;
    logic                   rv_q, rv_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Any sample agreeing with the accepted level restarts the stability count.
    always_comb begin
        btn_db_d = btn_db_q;
        cnt_d    = cnt_q;
        if (btn_sync == btn_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            btn_db_d = btn_sync;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            cnt_q         <= cnt_d;
        end
    end

    assign press = btn_db_q & ~btn_db_prev_q;

    // clr wins over a coincident press; that press is dropped, not queued.
    always_comb begin
        state_d   = state_q;
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        load_op_d = 1'b0;
        if (clr) begin
            state_d = ST_A;
        end else if (press) begin
            case (state_q)
                ST_A: begin
                    load_a_d = 1'b1;
                    state_d  = ST_B;
                end
                ST_B: begin
                    load_b_d = 1'b1;
                    state_d  = ST_OP;
                end
                ST_OP: begin
                    load_op_d = 1'b1;
                    state_d   = ST_SHOW;
                end
                ST_SHOW: begin
                    state_d = ST_A;
                end
            endcase
        end
        rv_d = (state_d == ST_SHOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_A;
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            load_op_q <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            load_op_q <= load_op_d;
            rv_q      <= rv_d;
        end
    end

    assign load_a       = load_a_q;
    assign load_b       = load_b_q;
    assign load_op      = load_op_q;
    assign stage        = state_q;
    assign result_valid = rv_q;

endmodule
